// File: rtl/instr_prefetch_queue_if.sv
// Bundles the instruction-memory read port and the consumer handshake of
// the prefetch queue. The master side is the prefetcher itself; the slave
// side is the memory plus the instruction consumer.
interface instr_prefetch_queue_if #(
    parameter int AW = 6
);
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_rdata;
    logic          instr_valid;
    logic [31:0]   instr_data;
    logic [AW-1:0] instr_pc;
    logic          instr_ready;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        output instr_valid,
        output instr_data,
        output instr_pc,
        input  instr_ready
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        input  instr_valid,
        input  instr_data,
        input  instr_pc,
        output instr_ready
    );
endinterface

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: fetches words from address 0 upward into a
// small FIFO until a zero sentinel word or the last memory address, then
// drains the FIFO to the consumer and pulses done.
// Optional build macro PREFETCH_STATS_EN adds saturating counters of
// enqueued words (stat_fetched) and consumer stall cycles (stat_stalls).
module instr_prefetch_queue #(
    parameter int  IMEM_DEPTH = 64,
    parameter int  QDEPTH     = 4,
    localparam int AW         = $clog2(IMEM_DEPTH),
    localparam int PW         = $clog2(QDEPTH),
    localparam int CW         = PW + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  flush,
    instr_prefetch_queue_if.master bus,
    output logic                  busy,
    output logic                  done,
    output logic [CW-1:0]         count
`ifdef PREFETCH_STATS_EN
    ,
    output logic [15:0]           stat_fetched,
    output logic [15:0]           stat_stalls
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] fetch_addr_q, fetch_addr_d;
    logic          addr_done_q, addr_done_d;
    logic          inflight_q;
    logic [AW-1:0] inflight_addr_q;
    logic [PW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CW-1:0] count_q;
    logic [31:0]   data_q [QDEPTH];
    logic [AW-1:0] pc_q   [QDEPTH];

    logic [CW:0]   occupancy;
    logic          room;
    logic          sentinel;
    logic          last_ret;
    logic          req;
    logic          enq;
    logic          deq;

    // Slots already promised (stored plus the read still returning) decide
    // whether another request can be issued without risking overflow.
    assign occupancy = {1'b0, count_q} + (CW+1)'(inflight_q);
    assign room      = occupancy < (CW+1)'(QDEPTH);
    assign sentinel  = inflight_q && (bus.imem_rdata == 32'h0);
    assign last_ret  = inflight_q && (inflight_addr_q == AW'(IMEM_DEPTH - 1));
    assign req       = (state_q == FETCH) && !addr_done_q && room && !sentinel && !flush;
    assign enq       = inflight_q && !sentinel && !flush;
    assign deq       = bus.instr_valid && bus.instr_ready && !flush;

    assign bus.imem_req    = req;
    assign bus.imem_addr   = fetch_addr_q;
    assign bus.instr_valid = (count_q != '0);
    assign bus.instr_data  = data_q[rd_ptr_q];
    assign bus.instr_pc    = pc_q[rd_ptr_q];
    assign busy            = (state_q != IDLE);
    assign count           = count_q;

    // Next-state, fetch-address stepping and the end-of-program done pulse.
    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        addr_done_d  = addr_done_q;
        done         = 1'b0;
        if (flush) begin
            state_d     = IDLE;
            addr_done_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d      = FETCH;
                        fetch_addr_d = '0;
                        addr_done_d  = 1'b0;
                    end
                end
                FETCH: begin
                    if (req) begin
                        if (fetch_addr_q == AW'(IMEM_DEPTH - 1)) begin
                            addr_done_d = 1'b1;
                        end else begin
                            fetch_addr_d = fetch_addr_q + AW'(1);
                        end
                    end
                    if (sentinel || last_ret) begin
                        state_d = DRAIN;
                    end
                end
                DRAIN: begin
                    if ((count_q == '0) && !inflight_q) begin
                        state_d = IDLE;
                        done    = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State register and fetch-address bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            fetch_addr_q <= '0;
            addr_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            addr_done_q  <= addr_done_d;
        end
    end

    // The outstanding read carries its own address so it becomes instr_pc.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q      <= 1'b0;
            inflight_addr_q <= '0;
        end else begin
            inflight_q <= req;
            if (req) begin
                inflight_addr_q <= fetch_addr_q;
            end
        end
    end

    // Circular buffer of returned words; flush empties it in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                data_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (enq) begin
                data_q[wr_ptr_q] <= bus.imem_rdata;
                pc_q[wr_ptr_q]   <= inflight_addr_q;
                wr_ptr_q         <= wr_ptr_q + PW'(1);
            end
            if (deq) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({enq, deq})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef PREFETCH_STATS_EN
    logic [15:0] fetched_q;
    logic [15:0] stalls_q;

    // Saturating statistics, cleared by an accepted start but kept across flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetched_q <= '0;
            stalls_q  <= '0;
        end else if (start && (state_q == IDLE) && !flush) begin
            fetched_q <= '0;
            stalls_q  <= '0;
        end else begin
            if (enq && (fetched_q != 16'hFFFF)) begin
                fetched_q <= fetched_q + 16'd1;
            end
            if (bus.instr_valid && !bus.instr_ready && (stalls_q != 16'hFFFF)) begin
                stalls_q <= stalls_q + 16'd1;
            end
        end
    end

    assign stat_fetched = fetched_q;
    assign stat_stalls  = stalls_q;
`endif

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed bench for instr_prefetch_queue: one 64-word instance for the
// main scenarios and one 8-word instance for the end-of-memory case.
module tb_instr_prefetch_queue;

    localparam int DEPTH_A = 64;
    localparam int AW_A    = 6;
    localparam int DEPTH_B = 8;
    localparam int AW_B    = 3;
    localparam int CW      = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic startA = 1'b0, flushA = 1'b0, busyA, doneA;
    logic startB = 1'b0, flushB = 1'b0, busyB, doneB;
    logic [CW-1:0] countA, countB;
`ifdef PREFETCH_STATS_EN
    logic [15:0] fetchedA, stallsA, fetchedB, stallsB;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] memA [DEPTH_A];
    logic [31:0] memB [DEPTH_B];

    instr_prefetch_queue_if #(.AW(AW_A)) busA ();
    instr_prefetch_queue_if #(.AW(AW_B)) busB ();

    instr_prefetch_queue #(.IMEM_DEPTH(DEPTH_A), .QDEPTH(4)) dutA (
        .clk(clk), .rst_n(rst_n), .start(startA), .flush(flushA), .bus(busA),
        .busy(busyA), .done(doneA), .count(countA)
`ifdef PREFETCH_STATS_EN
        , .stat_fetched(fetchedA), .stat_stalls(stallsA)
`endif
    );

    instr_prefetch_queue #(.IMEM_DEPTH(DEPTH_B), .QDEPTH(4)) dutB (
        .clk(clk), .rst_n(rst_n), .start(startB), .flush(flushB), .bus(busB),
        .busy(busyB), .done(doneB), .count(countB)
`ifdef PREFETCH_STATS_EN
        , .stat_fetched(fetchedB), .stat_stalls(stallsB)
`endif
    );

    // Clock generation.
    always #5 clk = ~clk;

    // Synchronous memories: data appears one cycle after the request.
    always @(posedge clk) begin
        if (busA.imem_req) busA.imem_rdata <= memA[busA.imem_addr];
        if (busB.imem_req) busB.imem_rdata <= memB[busB.imem_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        busA.instr_ready = 1'b0;
        busB.instr_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busA.imem_req !== 1'b0 || busA.imem_addr !== '0) begin
            errors++;
            $display("[TB] FAIL reset_imem: got req=%b addr=%0d expected req=0 addr=0", busA.imem_req, busA.imem_addr);
        end
        checks++;
        if (busA.instr_valid !== 1'b0 || busA.instr_data !== 32'h0 || busA.instr_pc !== '0) begin
            errors++;
            $display("[TB] FAIL reset_head: got valid=%b data=%h pc=%0d expected 0/0/0", busA.instr_valid, busA.instr_data, busA.instr_pc);
        end
        checks++;
        if (busyA !== 1'b0 || doneA !== 1'b0 || countA !== '0) begin
            errors++;
            $display("[TB] FAIL reset_status: got busy=%b done=%b count=%0d expected 0/0/0", busyA, doneA, countA);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int idx, firstCyc, lastCyc, doneCyc;
        bit consecutive;
        for (int i = 0; i < DEPTH_A; i++) memA[i] = 32'h0;
        memA[0] = 32'hA0A0_0001;
        memA[1] = 32'hA0A0_0002;
        memA[2] = 32'hA0A0_0003;
        busA.instr_ready = 1'b1;
        startA = 1'b1;
        tick();
        startA = 1'b0;
        idx = 0; firstCyc = -1; lastCyc = -1; doneCyc = -1; consecutive = 1'b1;
        for (int c = 0; c < 30 && doneCyc < 0; c++) begin
            if (busA.instr_valid && busA.instr_ready) begin
                checks++;
                if (busA.instr_pc !== idx[5:0] || busA.instr_data !== memA[idx]) begin
                    errors++;
                    $display("[TB] FAIL basic_word%0d: got pc=%0d data=%h expected pc=%0d data=%h", idx, busA.instr_pc, busA.instr_data, idx, memA[idx]);
                end
                if (firstCyc < 0) firstCyc = c;
                if (lastCyc >= 0 && c != lastCyc + 1) consecutive = 1'b0;
                lastCyc = c;
                idx++;
            end
            if (doneA) doneCyc = c;
            if (doneCyc < 0) tick();
        end
        checks++;
        if (idx != 3 || !consecutive) begin
            errors++;
            $display("[TB] FAIL basic_count: got %0d words consecutive=%0b expected 3 consecutive", idx, consecutive);
        end
        checks++;
        if (firstCyc != 2) begin
            errors++;
            $display("[TB] FAIL basic_latency: got first word at cycle %0d expected 2", firstCyc);
        end
        checks++;
        if (doneCyc < 0 || doneCyc != lastCyc + 1) begin
            errors++;
            $display("[TB] FAIL basic_done: got done at cycle %0d expected %0d", doneCyc, lastCyc + 1);
        end
        tick();
        checks++;
        if (busyA !== 1'b0 || doneA !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_idle: got busy=%b done=%b expected 0/0", busyA, doneA);
        end
    endtask

    task automatic test_backpressure();
        int waited, idx, maxCount;
        bit doneSeen;
        for (int i = 0; i < DEPTH_A; i++) memA[i] = 32'h0;
        for (int i = 0; i < 12; i++) memA[i] = 32'hB000_0000 + i + 1;
        busA.instr_ready = 1'b0;
        startA = 1'b1;
        tick();
        startA = 1'b0;
        waited = 0;
        while (!busA.instr_valid && waited < 20) begin
            tick();
            waited++;
        end
        checks++;
        if (!busA.instr_valid) begin
            errors++;
            $display("[TB] FAIL bp_first_valid: got valid=%b after %0d cycles expected 1", busA.instr_valid, waited);
        end
        maxCount = 0;
        for (int s = 1; s <= 10; s++) begin
            if (s > 1) tick();
            startA = (s == 5);
            if (int'(countA) > maxCount) maxCount = int'(countA);
            checks++;
            if (busA.instr_valid !== 1'b1 || busA.instr_pc !== 6'd0 || busA.instr_data !== memA[0]) begin
                errors++;
                $display("[TB] FAIL bp_head_hold%0d: got valid=%b pc=%0d data=%h expected 1/0/%h", s, busA.instr_valid, busA.instr_pc, busA.instr_data, memA[0]);
            end
            if (countA == 3'd4) begin
                checks++;
                if (busA.imem_req !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL bp_req_when_full%0d: got req=%b expected 0", s, busA.imem_req);
                end
            end
        end
        startA = 1'b0;
        checks++;
        if (countA !== 3'd4 || maxCount != 4 || busA.imem_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_saturate: got count=%0d max=%0d req=%b expected 4/4/0", countA, maxCount, busA.imem_req);
        end
        tick();
        busA.instr_ready = 1'b1;
        idx = 0;
        doneSeen = 1'b0;
        for (int c = 0; c < 60 && !doneSeen; c++) begin
            if (busA.instr_valid && busA.instr_ready) begin
                checks++;
                if (busA.instr_pc !== idx[5:0] || busA.instr_data !== memA[idx]) begin
                    errors++;
                    $display("[TB] FAIL bp_word%0d: got pc=%0d data=%h expected pc=%0d data=%h", idx, busA.instr_pc, busA.instr_data, idx, memA[idx]);
                end
                idx++;
            end
            if (doneA) doneSeen = 1'b1;
            else tick();
        end
        checks++;
        if (idx != 12 || !doneSeen) begin
            errors++;
            $display("[TB] FAIL bp_total: got %0d words done=%0b expected 12 words done=1", idx, doneSeen);
        end
`ifdef PREFETCH_STATS_EN
        checks++;
        if (fetchedA !== 16'd12 || stallsA !== 16'd10) begin
            errors++;
            $display("[TB] FAIL bp_stats: got fetched=%0d stalls=%0d expected 12/10", fetchedA, stallsA);
        end
`endif
        tick();
    endtask

    task automatic test_flush();
        int waited;
        bit sawDone;
        busA.instr_ready = 1'b0;
        startA = 1'b1;
        tick();
        startA = 1'b0;
        waited = 0;
        while (countA != 3'd3 && waited < 20) begin
            tick();
            waited++;
        end
        checks++;
        if (countA !== 3'd3) begin
            errors++;
            $display("[TB] FAIL flush_setup: got count=%0d expected 3", countA);
        end
        flushA = 1'b1;
        tick();
        flushA = 1'b0;
        checks++;
        if (countA !== '0 || busA.instr_valid !== 1'b0 || busyA !== 1'b0 || doneA !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_clear: got count=%0d valid=%b busy=%b done=%b expected 0/0/0/0", countA, busA.instr_valid, busyA, doneA);
        end
`ifdef PREFETCH_STATS_EN
        checks++;
        if (fetchedA !== 16'd3 || stallsA !== 16'd3) begin
            errors++;
            $display("[TB] FAIL flush_stats: got fetched=%0d stalls=%0d expected 3/3", fetchedA, stallsA);
        end
`endif
        sawDone = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (doneA || busA.instr_valid || busA.imem_req) sawDone = 1'b1;
        end
        checks++;
        if (sawDone) begin
            errors++;
            $display("[TB] FAIL flush_quiet: got activity after flush expected none");
        end
        busA.instr_ready = 1'b1;
        startA = 1'b1;
        tick();
        startA = 1'b0;
        waited = 0;
        while (!busA.instr_valid && waited < 20) begin
            tick();
            waited++;
        end
        checks++;
        if (busA.instr_valid !== 1'b1 || busA.instr_pc !== 6'd0 || busA.instr_data !== memA[0]) begin
            errors++;
            $display("[TB] FAIL flush_restart: got valid=%b pc=%0d data=%h expected 1/0/%h", busA.instr_valid, busA.instr_pc, busA.instr_data, memA[0]);
        end
        waited = 0;
        while (busyA && waited < 60) begin
            tick();
            waited++;
        end
        checks++;
        if (busyA !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_rerun_end: got busy=%b expected 0", busyA);
        end
    endtask

    task automatic test_depth_end();
        int idx, reqs;
        bit doneSeen;
        for (int i = 0; i < DEPTH_B; i++) memB[i] = 32'hC000_0000 + i + 1;
        busB.instr_ready = 1'b1;
        startB = 1'b1;
        tick();
        startB = 1'b0;
        idx = 0; reqs = 0; doneSeen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (busB.imem_req) reqs++;
            if (busB.instr_valid && busB.instr_ready) begin
                checks++;
                if (busB.instr_pc !== idx[2:0] || busB.instr_data !== memB[idx[2:0]]) begin
                    errors++;
                    $display("[TB] FAIL end_word%0d: got pc=%0d data=%h expected pc=%0d data=%h", idx, busB.instr_pc, busB.instr_data, idx, memB[idx[2:0]]);
                end
                idx++;
            end
            if (doneB) doneSeen = 1'b1;
            tick();
        end
        checks++;
        if (idx != 8 || reqs != 8) begin
            errors++;
            $display("[TB] FAIL end_counts: got words=%0d requests=%0d expected 8/8", idx, reqs);
        end
        checks++;
        if (!doneSeen || busyB !== 1'b0) begin
            errors++;
            $display("[TB] FAIL end_done: got done_seen=%0b busy=%b expected 1/0", doneSeen, busyB);
        end
    endtask

    task automatic test_async_reset();
        busA.instr_ready = 1'b0;
        startA = 1'b1;
        tick();
        startA = 1'b0;
        repeat (4) tick();
        checks++;
        if (busyA !== 1'b1 || countA == '0) begin
            errors++;
            $display("[TB] FAIL areset_setup: got busy=%b count=%0d expected busy=1 count>0", busyA, countA);
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busA.imem_req !== 1'b0 || busA.imem_addr !== '0 || busA.instr_valid !== 1'b0 ||
            busA.instr_data !== 32'h0 || busA.instr_pc !== '0) begin
            errors++;
            $display("[TB] FAIL areset_bus: got req=%b addr=%0d valid=%b data=%h pc=%0d expected all 0",
                     busA.imem_req, busA.imem_addr, busA.instr_valid, busA.instr_data, busA.instr_pc);
        end
        checks++;
        if (busyA !== 1'b0 || doneA !== 1'b0 || countA !== '0) begin
            errors++;
            $display("[TB] FAIL areset_status: got busy=%b done=%b count=%0d expected 0/0/0", busyA, doneA, countA);
        end
`ifdef PREFETCH_STATS_EN
        checks++;
        if (fetchedA !== 16'd0 || stallsA !== 16'd0) begin
            errors++;
            $display("[TB] FAIL areset_stats: got fetched=%0d stalls=%0d expected 0/0", fetchedA, stallsA);
        end
`endif
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (busyA !== 1'b0 || doneA !== 1'b0 || busA.instr_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL areset_after: got busy=%b done=%b valid=%b expected 0/0/0", busyA, doneA, busA.instr_valid);
        end
    endtask

    initial begin
        $display("[TB] starting instr_prefetch_queue bench");
        test_reset();
        test_basic();
        test_backpressure();
        test_flush();
        test_depth_end();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_prefetch_queue.md
INSTR_PREFETCH_QUEUE -- requirements
Module: instr_prefetch_queue

Interface
REQ-001 SHALL have parameter IMEM_DEPTH, default 64, meaning instruction memory depth in words; AW = $clog2(IMEM_DEPTH).
REQ-002 SHALL have parameter QDEPTH, default 4, meaning queue entries (power of two, >= 2).
REQ-003 SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port start, input, 1 bit: pulse that begins fetch at address 0; honoured in IDLE only.
REQ-006 SHALL have port flush, input, 1 bit: discard queue and in-flight read, return to IDLE.
REQ-007 SHALL have port imem_req, output, 1 bit: read request to instruction memory.
REQ-008 SHALL have port imem_addr, output, AW bits: read address.
REQ-009 SHALL have port imem_rdata, input, 32 bits: read data, valid exactly 1 cycle after imem_req.
REQ-010 SHALL have port instr_valid, output, 1 bit: queue head valid.
REQ-011 SHALL have port instr_data, output, 32 bits: queue head instruction word.
REQ-012 SHALL have port instr_pc, output, AW bits: address of the head word.
REQ-013 SHALL have port instr_ready, input, 1 bit: consumer accepts head when high with instr_valid.
REQ-014 SHALL have port busy, output, 1 bit: high in FETCH or DRAIN.
REQ-015 SHALL have port done, output, 1 bit: 1-cycle pulse at program end.
REQ-016 SHALL have port count, output, $clog2(QDEPTH)+1 bits: current occupancy.

Function
REQ-017 SHALL implement FSM states IDLE, FETCH, DRAIN.
REQ-018 IDLE -> FETCH on start; next fetch address set to 0.
REQ-019 In FETCH, imem_req SHALL assert only when count + inflight < QDEPTH; inflight is 1 in the cycle after a request.
REQ-020 Each request SHALL increment the fetch address by 1; the address of each request travels with it to become instr_pc.
REQ-021 A returned word of 32'h0 is the end sentinel: not enqueued; no further requests; FETCH -> DRAIN.
REQ-022 After a request to address IMEM_DEPTH-1 whose data is non-zero, the word SHALL be enqueued and FETCH -> DRAIN; the address never wraps to 0.
REQ-023 DRAIN -> IDLE when count == 0 and inflight == 0; done SHALL pulse in the same cycle as the transition.
REQ-024 Handshake: a word leaves the queue on instr_valid && instr_ready; instr_data and instr_pc are held stable while instr_valid && !instr_ready.
REQ-025 Simultaneous enqueue and dequeue SHALL leave count unchanged; the queue SHALL never overflow or underflow.
REQ-026 Head data is registered; enqueue-to-instr_valid latency is 1 cycle (request at cycle N, data at N+1, instr_valid at N+2).
REQ-027 flush SHALL have priority over start and all other events; the next cycle: state IDLE, count 0, in-flight data dropped, done not pulsed.
REQ-028 start while busy SHALL be ignored.
REQ-029 Throughput: with instr_ready held high, SHALL sustain one instruction per cycle after the initial 2-cycle latency.

Reset
REQ-030 On rst_n low, SHALL asynchronously enter IDLE with imem_req=0, imem_addr=0, instr_valid=0, instr_data=0, instr_pc=0, busy=0, done=0, count=0, inflight=0.
REQ-031 Reset mid-operation SHALL discard all queue contents and in-flight reads; no done pulse.

Configuration
REQ-032 Macro PREFETCH_STATS_EN SHALL, when defined, add output stat_fetched (16 bits, enqueued words) and output stat_stalls (16 bits, cycles with instr_valid && !instr_ready).
REQ-033 Both counters SHALL saturate at 16'hFFFF, clear on reset and on start, and be unaffected by flush.
REQ-034 Without PREFETCH_STATS_EN, the ports and counters SHALL be absent and all other behaviour identical.

Verification
REQ-035 Memory {A0,A1,A2,0}, ready=1, pulse start -> instr_pc 0,1,2 on consecutive cycles with data A0..A2, then done pulse, busy=0.
REQ-036 12 non-zero words, ready=0 for 10 cycles -> count saturates at 4, imem_req low while full, head stays A0/pc 0; after release all 12 words arrive in order.
REQ-037 IMEM_DEPTH=8, all words non-zero -> 8 words delivered (pc 0..7), no request to address 0 after pc 7, done pulses.
REQ-038 flush asserted at the same cycle as a returning read, queue holding 3 -> next cycle count=0, instr_valid=0, IDLE, no done; a new start refetches from pc 0.
REQ-039 rst_n asserted low mid-FETCH (asynchronous) -> all outputs at reset values before the next clock edge.
REQ-040 With PREFETCH_STATS_EN, the REQ-036 stimulus -> stat_fetched=12, stat_stalls=10.
